// File: rtl/vfu_vrf_wb_arbiter_if.sv
// vfu_vrf_wb_arbiter_if: one VRF write channel (result bundle plus req/gnt handshake)
interface vfu_vrf_wb_arbiter_if #(
  parameter type         vid_t     = logic [3:0],
  parameter type         vaddr_t   = logic [7:0],
  parameter int unsigned DataWidth = 64
);
  logic                   req;
  vid_t                   id;
  vaddr_t                 addr;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] be;
  logic                   gnt;
  modport master (output req, id, addr, wdata, be, input gnt);
  modport slave (input req, id, addr, wdata, be, output gnt);
endinterface

// File: rtl/vfu_vrf_wb_arbiter.sv
// vfu_vrf_wb_arbiter: buffered ALU/MFPU write-back arbiter onto one VRF write port
module vfu_vrf_wb_arbiter #(
  parameter type         vid_t     = logic [3:0],
  parameter type         vaddr_t   = logic [7:0],
  parameter int unsigned DataWidth = 64,
  parameter int unsigned BufDepth  = 2,
  parameter int unsigned MaxWait   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  vfu_vrf_wb_arbiter_if.slave    alu_i,
  vfu_vrf_wb_arbiter_if.slave    mfpu_i,
  vfu_vrf_wb_arbiter_if.master   vrf_o,
  output logic                   vrf_src_o,
  output logic                   busy_o
);
  localparam int unsigned PtrW  = BufDepth > 1 ? $clog2(BufDepth) : 1;
  localparam int unsigned CntW  = $clog2(BufDepth + 1);
  localparam int unsigned WaitW = $clog2(MaxWait + 1);

  typedef struct packed {
    vid_t                   id;
    vaddr_t                 addr;
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] be;
  } entry_t;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic [WaitW-1:0] wait_q, wait_d;
  entry_t           mem_q [2][BufDepth];
  logic [PtrW-1:0]  wp_q [2];
  logic [PtrW-1:0]  rp_q [2];
  logic [CntW-1:0]  cnt_q [2];
  entry_t           din [2];
  entry_t           head;
  logic [1:0]       req, gnt, full, empty, pop;
  logic             vrf_req;

  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return p == PtrW'(BufDepth - 1) ? '0 : p + 1'b1;
  endfunction

  // index 0 is the ALU buffer, index 1 the MFPU buffer
  assign req    = {mfpu_i.req, alu_i.req};
  assign din[0] = {alu_i.id, alu_i.addr, alu_i.wdata, alu_i.be};
  assign din[1] = {mfpu_i.id, mfpu_i.addr, mfpu_i.wdata, mfpu_i.be};

  for (genvar i = 0; i < 2; i++) begin : g_flag
    assign full[i]  = cnt_q[i] == CntW'(BufDepth);
    assign empty[i] = cnt_q[i] == '0;
  end

  assign gnt        = {2{rst_ni}} & req & (~full | pop);
  assign alu_i.gnt  = gnt[0];
  assign mfpu_i.gnt = gnt[1];

  // a stalled selection stays locked so the presented write never changes before gnt
  always_comb begin
    vrf_req = rst_ni & (~empty[0] | ~empty[1]);
    sel_d   = state_q == LOCKED ? sel_q : empty[0] ? 1'b1 : empty[1] ? 1'b0 : wait_q == WaitW'(MaxWait);
    state_d = vrf_req ? (vrf_o.gnt ? IDLE : LOCKED) : state_q;
    pop     = {2{vrf_req & vrf_o.gnt}} & {sel_d, ~sel_d};
    wait_d  = pop[1] ? '0 : (~empty[1] && wait_q != WaitW'(MaxWait)) ? wait_q + 1'b1 : wait_q;
  end

  assign head        = vrf_req ? mem_q[sel_d][rp_q[sel_d]] : '0;
  assign vrf_o.req   = vrf_req;
  assign vrf_o.id    = head.id;
  assign vrf_o.addr  = head.addr;
  assign vrf_o.wdata = head.data;
  assign vrf_o.be    = head.be;
  assign vrf_src_o   = vrf_req & sel_d;
  assign busy_o      = vrf_req;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      wait_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      for (int i = 0; i < 2; i++) begin
        if (gnt[i]) begin
          mem_q[i][wp_q[i]] <= din[i];
          wp_q[i]           <= inc(wp_q[i]);
        end
        if (pop[i]) rp_q[i] <= inc(rp_q[i]);
        cnt_q[i] <= cnt_q[i] + CntW'(gnt[i]) - CntW'(pop[i]);
      end
    end
  end
endmodule
